// File: rtl/pool1_tx_pkg.sv
// Shared constants for the pool1 -> conv2 row hand-off (transmit and capture sides).
// Both ends leave reset at PHASE_RST so their frame counters stay in lock-step.
package pool1_tx_pkg;

    localparam int PIX_W     = 16;
    localparam int ROW_PIX   = 14;
    localparam int FRAME_LEN = 26;
    localparam int LOAD_PH   = 20;
    localparam int CAP1_PH   = 2;
    localparam int CAP2_PH   = 14;
    localparam int PHASE_RST = 2;
    localparam int PHASE_W   = 5;

    // Frame phase successor: 0 .. frame_len-1, then wrap to 0.
    function automatic logic [PHASE_W-1:0] next_phase(input logic [PHASE_W-1:0] ph,
                                                      input int frame_len);
        if (ph == PHASE_W'(frame_len - 1)) begin
            return '0;
        end
        return ph + 1'b1;
    endfunction

endpackage

// File: rtl/pool1_row_packer.sv
// Packs accepted pixels LSB-first into one ROW_PIX-pixel row.
// row_done/row are combinational so the completed row is available on the accepting edge.
module pool1_row_packer
    import pool1_tx_pkg::*;
#(
    parameter int PIX_W_P   = PIX_W,
    parameter int ROW_PIX_P = ROW_PIX
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           pix_accept,
    input  logic [PIX_W_P-1:0]             pix_data,
    output logic                           row_done,
    output logic [PIX_W_P*ROW_PIX_P-1:0]   row
);

    localparam int RW    = PIX_W_P * ROW_PIX_P;
    localparam int IDX_W = $clog2(ROW_PIX_P);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROW_PIX_P - 1);

    logic [IDX_W-1:0] idx;
    logic [RW-1:0]    row_q;
    logic [RW-1:0]    row_next;

    always_comb begin
        row_next = row_q;
        row_next[int'(idx)*PIX_W_P +: PIX_W_P] = pix_data;
    end

    assign row_done = pix_accept && (idx == LAST_IDX);
    assign row      = row_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            idx   <= '0;
            row_q <= '0;
        end else if (pix_accept) begin
            if (idx == LAST_IDX) begin
                idx   <= '0;
                row_q <= '0;
            end else begin
                idx   <= idx + 1'b1;
                row_q <= row_next;
            end
        end
    end

endmodule

// File: rtl/pool1_tx.sv
// pool1 -> conv2 transmit side: packs pixels into row pairs and presents one pair per frame.
// Build option POOL1_TX_ZERO_ON_UNDERRUN_EN: load zero rows when a load finds no complete pair.
module pool1_tx
    import pool1_tx_pkg::*;
#(
    parameter int PIX_W_P     = PIX_W,
    parameter int ROW_PIX_P   = ROW_PIX,
    parameter int FRAME_LEN_P = FRAME_LEN,
    parameter int LOAD_PH_P   = LOAD_PH
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           pix_valid,
    input  logic [PIX_W_P-1:0]             pix_data,
    output logic                           pix_ready,
    output logic [PIX_W_P*ROW_PIX_P-1:0]   out_pool1_1,
    output logic [PIX_W_P*ROW_PIX_P-1:0]   out_pool1_2,
    output logic [PHASE_W-1:0]             phase,
    output logic                           pair_sent,
    output logic                           underrun
);

    localparam int RW = PIX_W_P * ROW_PIX_P;

    // Handshake: a pixel transfers on the rising edge where pix_valid & pix_ready;
    // pix_ready is a pure register term and never depends on pix_valid.
    logic          pix_accept;
    logic          row_done;
    logic [RW-1:0] packed_row;
    logic [RW-1:0] slot_a;
    logic [RW-1:0] slot_b;
    logic          slot_sel;
    logic          pair_full;
    logic          load_now;

    assign pix_ready  = ~pair_full;
    assign pix_accept = pix_valid & pix_ready;
    assign load_now   = (phase == PHASE_W'(LOAD_PH_P));

    pool1_row_packer #(
        .PIX_W_P   (PIX_W_P),
        .ROW_PIX_P (ROW_PIX_P)
    ) u_packer (
        .clk        (clk),
        .rst        (rst),
        .pix_accept (pix_accept),
        .pix_data   (pix_data),
        .row_done   (row_done),
        .row        (packed_row)
    );

    // row_done and a full-pair load never coincide: accepts stop while pair_full.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase       <= PHASE_W'(PHASE_RST);
            slot_a      <= '0;
            slot_b      <= '0;
            slot_sel    <= 1'b0;
            pair_full   <= 1'b0;
            out_pool1_1 <= '0;
            out_pool1_2 <= '0;
            pair_sent   <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            phase     <= next_phase(phase, FRAME_LEN_P);
            pair_sent <= 1'b0;
            underrun  <= 1'b0;

            if (row_done) begin
                if (!slot_sel) begin
                    slot_a   <= packed_row;
                    slot_sel <= 1'b1;
                end else begin
                    slot_b    <= packed_row;
                    slot_sel  <= 1'b0;
                    pair_full <= 1'b1;
                end
            end

            if (load_now) begin
                if (pair_full) begin
                    out_pool1_1 <= slot_a;
                    out_pool1_2 <= slot_b;
                    pair_full   <= 1'b0;
                    pair_sent   <= 1'b1;
                end else begin
`ifdef POOL1_TX_ZERO_ON_UNDERRUN_EN
                    out_pool1_1 <= '0;
                    out_pool1_2 <= '0;
`endif
                    underrun <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pool1_tx.sv
// Directed bench for pool1_tx with a conv2-side capture model (phases 2 and 14).
module tb_pool1_tx;
    import pool1_tx_pkg::*;

    localparam int RW = PIX_W * ROW_PIX;

    logic               clk;
    logic               rst;
    logic               pix_valid;
    logic [PIX_W-1:0]   pix_data;
    logic               pix_ready;
    logic [RW-1:0]      out_pool1_1;
    logic [RW-1:0]      out_pool1_2;
    logic [PHASE_W-1:0] phase;
    logic               pair_sent;
    logic               underrun;

    int n_cmp = 0;
    int n_bad = 0;
    int n_cap = 0;

    logic [RW-1:0] exp_q[$];

    pool1_tx dut (
        .clk         (clk),
        .rst         (rst),
        .pix_valid   (pix_valid),
        .pix_data    (pix_data),
        .pix_ready   (pix_ready),
        .out_pool1_1 (out_pool1_1),
        .out_pool1_2 (out_pool1_2),
        .phase       (phase),
        .pair_sent   (pair_sent),
        .underrun    (underrun)
    );

    // clock / watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [RW-1:0] make_row(input int base);
        logic [RW-1:0] r;
        r = '0;
        for (int k = 0; k < ROW_PIX; k++) begin
            r[k*PIX_W +: PIX_W] = PIX_W'(base + k);
        end
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_phase(input int p);
        int n;
        n = 0;
        while (phase != PHASE_W'(p) && n < 40) begin
            step();
            n++;
        end
        check("wait_phase", RW'(phase), RW'(p));
    endtask

    // Offer one pixel and hold it until accepted; reports stall cycles.
    task automatic send_pixel(input int v, output int stalls);
        logic rdy;
        logic accepted;
        pix_valid = 1'b1;
        pix_data  = PIX_W'(v);
        stalls    = 0;
        accepted  = 1'b0;
        while (!accepted && stalls < 60) begin
            rdy = pix_ready;
            step();
            if (rdy) accepted = 1'b1;
            else     stalls++;
        end
        check("accept", RW'(accepted), RW'(1));
    endtask

    // conv2 capture model: a pair announced by pair_sent is captured at the next
    // bank-1 and bank-2 capture phases and compared against the expected queue.
    logic          new_pair = 1'b0;
    logic          armed    = 1'b0;
    logic [RW-1:0] cap1;

    always @(posedge clk) begin
        #1;
        if (rst) begin
            new_pair = 1'b0;
            armed    = 1'b0;
        end else begin
            if (phase == PHASE_W'(CAP1_PH) && new_pair) begin
                cap1     = out_pool1_1;
                armed    = 1'b1;
                new_pair = 1'b0;
            end else if (phase == PHASE_W'(CAP2_PH) && armed) begin
                armed = 1'b0;
                n_cap++;
                check("cap_expected", RW'(exp_q.size() >= 2), RW'(1));
                if (exp_q.size() >= 2) begin
                    check("cap_bank1", cap1, exp_q.pop_front());
                    check("cap_bank2", out_pool1_2, exp_q.pop_front());
                end
            end
            if (pair_sent) new_pair = 1'b1;
        end
    end

    logic [RW-1:0] hold1;
    logic [RW-1:0] hold2;

    initial begin
        int st;
        int tot;
        rst       = 1'b1;
        pix_valid = 1'b0;
        pix_data  = '0;

        // reset state
        repeat (3) step();
        check("rst_phase", RW'(phase), RW'(2));
        check("rst_ready", RW'(pix_ready), RW'(1));
        check("rst_out1", out_pool1_1, '0);
        check("rst_out2", out_pool1_2, '0);
        check("rst_sent", RW'(pair_sent), RW'(0));
        check("rst_under", RW'(underrun), RW'(0));
        rst = 1'b0;

        // 28 pixels 0..27 from phase 3, loaded at the phase-20 edge
        step();
        check("t2_start_phase", RW'(phase), RW'(3));
        exp_q.push_back(make_row(0));
        exp_q.push_back(make_row(14));
        tot = 0;
        for (int i = 0; i < 28; i++) begin
            send_pixel(i, st);
            tot += st;
            if (i == 17) check("t2_underrun_f0", RW'(underrun), RW'(1));
        end
        pix_valid = 1'b0;
        check("t2_stalls", RW'(tot), RW'(0));
        check("t2_phase_end", RW'(phase), RW'(5));
        check("t2_ready_low", RW'(pix_ready), RW'(0));
        wait_phase(20);
        check("t2_sent_pre", RW'(pair_sent), RW'(0));
        step();
        check("t2_sent", RW'(pair_sent), RW'(1));
        check("t2_out1", out_pool1_1, make_row(0));
        check("t2_out2", out_pool1_2, make_row(14));
        check("t2_ready_back", RW'(pix_ready), RW'(1));
        step();
        check("t2_sent_once", RW'(pair_sent), RW'(0));

        // idle frame -> underrun
        wait_phase(20);
        step();
        check("t3_underrun", RW'(underrun), RW'(1));
        check("t3_sent", RW'(pair_sent), RW'(0));
`ifdef POOL1_TX_ZERO_ON_UNDERRUN_EN
        hold1 = '0;
        hold2 = '0;
`else
        hold1 = make_row(0);
        hold2 = make_row(14);
`endif
        check("t3_out1", out_pool1_1, hold1);
        check("t3_out2", out_pool1_2, hold2);

        // 40 pixels back-to-back from phase 21; pixel 28 stalls until after the load
        exp_q.push_back(make_row(100));
        exp_q.push_back(make_row(114));
        for (int i = 0; i < 28; i++) send_pixel(100 + i, st);
        check("t4_ready_low", RW'(pix_ready), RW'(0));
        check("t4_phase_full", RW'(phase), RW'(23));
        send_pixel(128, st);
        check("t4_stalls", RW'(st), RW'(24));
        check("t4_phase_acc", RW'(phase), RW'(22));
        check("t4_out1", out_pool1_1, make_row(100));
        check("t4_out2", out_pool1_2, make_row(114));
        for (int i = 29; i < 40; i++) send_pixel(100 + i, st);
        pix_valid = 1'b0;
        check("t4_phase_end", RW'(phase), RW'(7));

        // pair completes exactly on the phase-20 edge: deferred one frame
        wait_phase(5);
`ifdef POOL1_TX_ZERO_ON_UNDERRUN_EN
        hold1 = '0;
        hold2 = '0;
`else
        hold1 = make_row(100);
        hold2 = make_row(114);
`endif
        exp_q.push_back(make_row(128));
        exp_q.push_back(make_row(142));
        for (int i = 140; i < 156; i++) send_pixel(i, st);
        pix_valid = 1'b0;
        check("t5_phase", RW'(phase), RW'(21));
        check("t5_underrun", RW'(underrun), RW'(1));
        check("t5_sent", RW'(pair_sent), RW'(0));
        check("t5_ready_low", RW'(pix_ready), RW'(0));
        check("t5_out1_hold", out_pool1_1, hold1);
        check("t5_out2_hold", out_pool1_2, hold2);
        wait_phase(20);
        step();
        check("t5_sent_next", RW'(pair_sent), RW'(1));
        check("t5_out1", out_pool1_1, make_row(128));
        check("t5_out2", out_pool1_2, make_row(142));

        // reset after 20 accepts, then a fresh pair
        wait_phase(15);
        for (int i = 0; i < 20; i++) send_pixel(200 + i, st);
        pix_valid = 1'b0;
        rst = 1'b1;
        step();
        check("t6_rst_phase", RW'(phase), RW'(2));
        check("t6_rst_ready", RW'(pix_ready), RW'(1));
        check("t6_rst_out1", out_pool1_1, '0);
        check("t6_rst_out2", out_pool1_2, '0);
        check("t6_rst_pulses", RW'({pair_sent, underrun}), RW'(0));
        rst = 1'b0;
        exp_q.push_back(make_row(300));
        exp_q.push_back(make_row(314));
        for (int i = 0; i < 28; i++) send_pixel(300 + i, st);
        pix_valid = 1'b0;
        check("t6_phase_end", RW'(phase), RW'(4));
        wait_phase(20);
        step();
        check("t6_sent", RW'(pair_sent), RW'(1));
        check("t6_out1", out_pool1_1, make_row(300));
        check("t6_out2", out_pool1_2, make_row(314));

        // let the capture model take the last pair
        wait_phase(15);
        check("sb_empty", RW'(exp_q.size()), RW'(0));
        check("sb_captures", RW'(n_cap), RW'(4));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
